uart_rx_deframer: RTL and testbench



---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_rx_fifo.sv | 75 +++++++
 rtl/uart_rx_deframer.sv | 218 +++++++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg : shared state, entry type and sample points for uart_rx_deframer
// Rev 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } uart_rx_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } uart_rx_entry_s;

  localparam logic [3:0] SAMPLE_MID = 4'd7;
  localparam logic [3:0] SAMPLE_END = 4'd15;

  // Index of the last data bit; out-of-range widths fall back to 8 bits.
  function automatic logic [2:0] last_bit_idx(input logic [3:0] n_bits);
    if (n_bits >= 4'd5 && n_bits <= 4'd8) begin
      return 3'(n_bits - 4'd1);
    end
    return 3'd7;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_fifo : synchronous FIFO of received entries, DEPTH a power of 2
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           push_i,
  input  uart_rx_entry_s entry_i,
  input  logic           pop_i,
  output uart_rx_entry_s entry_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  uart_rx_entry_s  mem_q [DEPTH];
  uart_rx_entry_s  mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push;
  logic            do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_i && (!full_o || do_pop);
  assign entry_o = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = entry_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_deframer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_deframer : 16x oversampling UART receiver with entry FIFO and
// valid/ready output. Define UART_RX_MAJORITY_EN for 3-sample majority voting.
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DIV_W-1:0] clk_div_i,
  input  logic [3:0]       n_bits_i,
  input  logic             parity_en_i,
  input  logic             parity_odd_i,
  input  logic             two_stop_i,
  input  logic             srx_pad_i,
  output logic [7:0]       rx_data_o,
  output logic             rx_perr_o,
  output logic             rx_ferr_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic             overrun_o,
  input  logic             clr_overrun_i,
  output logic             busy_o
);

  logic             sync1_q, sync2_q;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick;
  uart_rx_state_e   state_q, state_d;
  logic [3:0]       sc_q, sc_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             ferr_new;
  logic [2:0]       last_q, last_d;
  logic             pen_q, pen_d;
  logic             podd_q, podd_d;
  logic             two_q, two_d;
  logic             realign_q, realign_d;
  logic             push_q, push_d;
  uart_rx_entry_s   entry_q, entry_d;
  logic             overrun_q, overrun_d;
  logic             bit_v;
  logic             mid;
  uart_rx_entry_s   head;
  logic             fifo_full, fifo_empty, pop;

`ifdef UART_RX_MAJORITY_EN
  // The third vote (sc==8) only exists one tick after mid-bit, so value-dependent
  // actions are taken there.
  localparam logic [3:0] ACT_SC = SAMPLE_MID + 4'd1;
  logic [1:0] vote_q, vote_d;
  assign bit_v  = (vote_q[1] & vote_q[0]) | (vote_q[1] & sync2_q) | (vote_q[0] & sync2_q);
  assign vote_d = tick ? {vote_q[0], sync2_q} : vote_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) vote_q <= 2'b11;
    else       vote_q <= vote_d;
  end
`else
  localparam logic [3:0] ACT_SC = SAMPLE_MID;
  assign bit_v = sync2_q;
`endif

  assign tick  = (cnt_q >= clk_div_i);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;
  assign mid   = (sc_q == ACT_SC);

  always_comb begin
    state_d   = state_q;
    sc_d      = sc_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    last_d    = last_q;
    pen_d     = pen_q;
    podd_d    = podd_q;
    two_d     = two_q;
    realign_d = realign_q;
    entry_d   = entry_q;
    push_d    = 1'b0;
    ferr_new  = ferr_q | ~bit_v;
    if (tick) begin
      sc_d = sc_q + 4'd1;
      case (state_q)
        IDLE: begin
          sc_d = '0;
          if (realign_q) begin
            if (sync2_q) realign_d = 1'b0;
          end else if (!sync2_q) begin
            state_d = START;
            last_d  = last_bit_idx(n_bits_i);
            pen_d   = parity_en_i;
            podd_d  = parity_odd_i;
            two_d   = two_stop_i;
            shift_d = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end
        START: begin
          if (mid && bit_v) begin
            state_d = IDLE;
          end else if (sc_q == SAMPLE_END) begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
        DATA: begin
          if (mid) shift_d[bit_q] = bit_v;
          if (sc_q == SAMPLE_END) begin
            if (bit_q == last_q) state_d = pen_q ? PARITY : STOP1;
            else                 bit_d   = bit_q + 3'd1;
          end
        end
        PARITY: begin
          if (mid) perr_d = ((^shift_q) ^ bit_v) != podd_q;
          if (sc_q == SAMPLE_END) state_d = STOP1;
        end
        STOP1: begin
          if (mid) begin
            ferr_d = ferr_new;
            // Single stop: return to IDLE mid-bit so an early next start is caught.
            if (!two_q) begin
              state_d   = IDLE;
              push_d    = 1'b1;
              entry_d   = '{data: shift_q, perr: perr_q, ferr: ferr_new};
              realign_d = ferr_new;
            end
          end else if (sc_q == SAMPLE_END && two_q) begin
            state_d = STOP2;
          end
        end
        STOP2: begin
          if (mid) begin
            ferr_d    = ferr_new;
            state_d   = IDLE;
            push_d    = 1'b1;
            entry_d   = '{data: shift_q, perr: perr_q, ferr: ferr_new};
            realign_d = ferr_new;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign pop       = rx_valid_o && rx_ready_i;
  assign overrun_d = (overrun_q & ~clr_overrun_i) | (push_q & fifo_full & ~pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      cnt_q     <= '0;
      state_q   <= IDLE;
      sc_q      <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      last_q    <= 3'd7;
      pen_q     <= 1'b0;
      podd_q    <= 1'b0;
      two_q     <= 1'b0;
      realign_q <= 1'b0;
      push_q    <= 1'b0;
      entry_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      sync1_q   <= srx_pad_i;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      sc_q      <= sc_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      last_q    <= last_d;
      pen_q     <= pen_d;
      podd_q    <= podd_d;
      two_q     <= two_d;
      realign_q <= realign_d;
      push_q    <= push_d;
      entry_q   <= entry_d;
      overrun_q <= overrun_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_q),
    .entry_i (entry_q),
    .pop_i   (pop),
    .entry_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rx_valid_o = !fifo_empty;
  assign rx_data_o  = rx_valid_o ? head.data : 8'h00;
  assign rx_perr_o  = rx_valid_o & head.perr;
  assign rx_ferr_o  = rx_valid_o & head.ferr;
  assign overrun_o  = overrun_q;
  assign busy_o     = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deframer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_rx_deframer : directed frames with scoreboard-checked FIFO output
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_uart_rx_deframer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] clk_div;
  logic [3:0]  n_bits;
  logic        parity_en, parity_odd, two_stop;
  logic        srx;
  logic [7:0]  rx_data;
  logic        rx_perr, rx_ferr, rx_valid, rx_ready;
  logic        overrun, clr_overrun, busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [9:0]  exp_q [$];
  logic [9:0]  mon_e;

  always #5 clk = ~clk;

  uart_rx_deframer #(
    .DIV_W      (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clk_div_i     (clk_div),
    .n_bits_i      (n_bits),
    .parity_en_i   (parity_en),
    .parity_odd_i  (parity_odd),
    .two_stop_i    (two_stop),
    .srx_pad_i     (srx),
    .rx_data_o     (rx_data),
    .rx_perr_o     (rx_perr),
    .rx_ferr_o     (rx_ferr),
    .rx_valid_o    (rx_valid),
    .rx_ready_i    (rx_ready),
    .overrun_o     (overrun),
    .clr_overrun_i (clr_overrun),
    .busy_o        (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted head entry is compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: actual data 0x%0h perr %0b ferr %0b required none",
                 rx_data, rx_perr, rx_ferr);
      end else begin
        mon_e = exp_q.pop_front();
        check("pop_entry", {22'd0, rx_data, rx_perr, rx_ferr}, {22'd0, mon_e});
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int tick_clks();
    return int'(clk_div) + 1;
  endfunction

  task automatic exp_push(input logic [7:0] d, input logic pe, input logic fe);
    exp_q.push_back({d, pe, fe});
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit podd,
                            input bit pflip, input bit stop_v, input bit chk_lat);
    int         bc;
    logic [7:0] dm;
    logic       p;
    n_bits     = 4'(nb);
    parity_en  = pen;
    parity_odd = podd;
    bc = 16 * tick_clks();
    dm = d & 8'((1 << nb) - 1);
    p  = (^dm) ^ podd ^ pflip;
    srx = 1'b0;
    wait_clks(bc);
    for (int i = 0; i < nb; i++) begin
      srx = dm[i];
      wait_clks(bc);
    end
    if (pen) begin
      srx = p;
      wait_clks(bc);
    end
    srx = stop_v;
    if (chk_lat) begin
      wait_clks(6 * tick_clks());
      check("latency_early_valid", 32'(rx_valid), 32'd0);
      wait_clks(3 * tick_clks());
      check("latency_late_valid", 32'(rx_valid), 32'd1);
      wait_clks(7 * tick_clks());
    end else begin
      wait_clks(bc);
    end
    if (two_stop) begin
      srx = 1'b1;
      wait_clks(bc);
    end
    srx = 1'b1;
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      wait_clks(1);
      if (!rx_valid) break;
    end
    check("drain_valid_low", 32'(rx_valid), 32'd0);
    check("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    rx_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    logic [7:0] d3c;
    rst = 1'b1; srx = 1'b1; rx_ready = 1'b0; clr_overrun = 1'b0;
    clk_div = 16'd26; n_bits = 4'd8; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    wait_clks(4);
    check("reset_data",    32'(rx_data),  32'd0);
    check("reset_perr",    32'(rx_perr),  32'd0);
    check("reset_ferr",    32'(rx_ferr),  32'd0);
    check("reset_valid",   32'(rx_valid), 32'd0);
    check("reset_overrun", 32'(overrun),  32'd0);
    check("reset_busy",    32'(busy),     32'd0);
    rst = 1'b0;
    wait_clks(20);

    // 8N1 0x55 at divisor 26 with valid latency window.
    exp_push(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 8, 0, 0, 0, 1, 1);
    wait_clks(16 * tick_clks());
    drain();

    // 7E1 good parity then flipped parity.
    clk_div = 16'd3;
    bc = 16 * tick_clks();
    wait_clks(bc);
    exp_push(8'h23, 1'b0, 1'b0);
    send_frame(8'h23, 7, 1, 0, 0, 1, 0);
    exp_push(8'h23, 1'b1, 1'b0);
    send_frame(8'h23, 7, 1, 0, 1, 1, 0);
    wait_clks(2 * bc);
    drain();

    // Framing error followed by a long low line, then a clean frame.
    exp_push(8'h81, 1'b0, 1'b1);
    send_frame(8'h81, 8, 0, 0, 0, 0, 0);
    srx = 1'b0;
    wait_clks(12 * bc);
    check("realign_busy_low", 32'(busy), 32'd0);
    srx = 1'b1;
    wait_clks(2 * bc);
    exp_push(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 8, 0, 0, 0, 1, 0);
    wait_clks(2 * bc);
    drain();

    // 3-tick low glitch on an idle line.
    srx = 1'b0;
    wait_clks(3 * tick_clks() - 1);
    check("glitch_busy_high", 32'(busy), 32'd1);
    wait_clks(1);
    srx = 1'b1;
    wait_clks(12 * tick_clks());
    check("glitch_busy_low", 32'(busy), 32'd0);
    check("glitch_no_push", 32'(rx_valid), 32'd0);

    // Overrun with ready held low.
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) exp_push(8'(k), 1'b0, 1'b0);
      if (k == 5) check("overrun_before_drop", 32'(overrun), 32'd0);
      send_frame(8'(k), 8, 0, 0, 0, 1, 0);
    end
    wait_clks(bc);
    check("overrun_set", 32'(overrun), 32'd1);
    check("overrun_valid_held", 32'(rx_valid), 32'd1);
    drain();
    check("overrun_sticky", 32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    wait_clks(1);
    clr_overrun = 1'b0;
    check("overrun_cleared", 32'(overrun), 32'd0);

    // Reset mid-frame during data bit 3 with an entry already queued.
    send_frame(8'h77, 8, 0, 0, 0, 1, 0);
    wait_clks(bc);
    check("pre_reset_valid", 32'(rx_valid), 32'd1);
    d3c = 8'h3C;
    srx = 1'b0;
    wait_clks(bc);
    for (int i = 0; i < 3; i++) begin
      srx = d3c[i];
      wait_clks(bc);
    end
    srx = d3c[3];
    wait_clks(bc / 2);
    check("midframe_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    srx = 1'b1;
    check("post_reset_valid", 32'(rx_valid), 32'd0);
    wait_clks(3 * bc);
    check("post_reset_valid_late", 32'(rx_valid), 32'd0);
    check("post_reset_busy", 32'(busy), 32'd0);
    exp_push(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 8, 0, 0, 0, 1, 0);
    wait_clks(bc);
    drain();

    check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
